// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and widths for the pipelined bitwise gate/tristate unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 4'd0,
    OP_OR     = 4'd1,
    OP_NAND   = 4'd2,
    OP_NOR    = 4'd3,
    OP_XOR    = 4'd4,
    OP_XNOR   = 4'd5,
    OP_BUF    = 4'd6,
    OP_NOT    = 4'd7,
    OP_BUFIF1 = 4'd8,
    OP_BUFIF0 = 4'd9,
    OP_NOTIF1 = 4'd10,
    OP_NOTIF0 = 4'd11
  } op_e;

  // Highest legal opcode; anything above is reported through err.
  localparam logic [OP_W-1:0] OP_LAST = 4'd11;

endpackage

// File: rtl/logic_unit_if.sv
// Producer-side and consumer-side handshake bundle for logic_unit_pipe.
interface logic_unit_if #(
  parameter int unsigned WIDTH = 8
);
  import logic_unit_pkg::*;

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             chain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] oe;
  logic             err;
  logic             zero;
  logic             parity;
  logic [CW-1:0]    drive_cnt;

  modport master (
    output in_valid, a, b, op, chain, out_ready,
    input  in_ready, out_valid, y, oe, err, zero, parity, drive_cnt
  );

  modport slave (
    input  in_valid, a, b, op, chain, out_ready,
    output in_ready, out_valid, y, oe, err, zero, parity, drive_cnt
  );

endinterface

// File: rtl/logic_unit_core.sv
// Combinational gate/tristate evaluator; tristate is expressed as an explicit drive-enable vector.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] oe_o,
  output logic             err_o
);

  always_comb begin
    y_o   = '0;
    oe_o  = '1;
    err_o = (op_i > OP_LAST);
    case (op_i)
      OP_AND:    y_o = a_i & b_i;
      OP_OR:     y_o = a_i | b_i;
      OP_NAND:   y_o = ~(a_i & b_i);
      OP_NOR:    y_o = ~(a_i | b_i);
      OP_XOR:    y_o = a_i ^ b_i;
      OP_XNOR:   y_o = ~(a_i ^ b_i);
      OP_BUF:    y_o = a_i;
      OP_NOT:    y_o = ~a_i;
      OP_BUFIF1: begin y_o = a_i;  oe_o = b_i;  end
      OP_BUFIF0: begin y_o = a_i;  oe_o = ~b_i; end
      OP_NOTIF1: begin y_o = ~a_i; oe_o = b_i;  end
      OP_NOTIF0: begin y_o = ~a_i; oe_o = ~b_i; end
      default: begin
        y_o  = '0;
        oe_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready streaming bit-manipulation stage with accumulator chaining and result flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  logic_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic [WIDTH-1:0] s1_oe_q, s1_oe_d;
  logic             s1_err_q, s1_err_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic [WIDTH-1:0] s2_oe_q, s2_oe_d;
  logic             s2_err_q, s2_err_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic             s2_load;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_oe;
  logic             core_err;
  logic [CW-1:0]    pop_c;

  assign bus.in_ready = !s1_v_q || !s2_v_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign s2_load      = s1_v_q && (!s2_v_q || bus.out_ready);
  assign a_eff        = bus.chain ? acc_q : bus.a;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (a_eff),
    .b_i   (bus.b),
    .op_i  (bus.op),
    .y_o   (core_y),
    .oe_o  (core_oe),
    .err_o (core_err)
  );

  // Drive count of the stage-1 enable vector, registered into stage 2.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_c = pop_c + CW'(s1_oe_q[i]);
    end
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_y_d   = s1_y_q;
    s1_oe_d  = s1_oe_q;
    s1_err_d = s1_err_q;
    s2_v_d   = s2_v_q;
    s2_y_d   = s2_y_q;
    s2_oe_d  = s2_oe_q;
    s2_err_d = s2_err_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;

    if (accept) begin
      s1_v_d   = 1'b1;
      s1_y_d   = core_y;
      s1_oe_d  = core_oe;
      s1_err_d = core_err;
      if (!core_err) begin
        acc_d = core_y;
      end
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end

    if (s2_load) begin
      s2_v_d   = 1'b1;
      s2_y_d   = s1_y_q;
      s2_oe_d  = s1_oe_q;
      s2_err_d = s1_err_q;
      zero_d   = ~|(s1_y_q & s1_oe_q);
      parity_d = ^(s1_y_q & s1_oe_q);
      cnt_d    = pop_c;
    end else if (bus.out_ready) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_y_q   <= '0;
      s1_oe_q  <= '0;
      s1_err_q <= 1'b0;
      s2_v_q   <= 1'b0;
      s2_y_q   <= '0;
      s2_oe_q  <= '0;
      s2_err_q <= 1'b0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_y_q   <= s1_y_d;
      s1_oe_q  <= s1_oe_d;
      s1_err_q <= s1_err_d;
      s2_v_q   <= s2_v_d;
      s2_y_q   <= s2_y_d;
      s2_oe_q  <= s2_oe_d;
      s2_err_q <= s2_err_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.out_valid = s2_v_q;
  assign bus.y         = s2_y_q;
  assign bus.oe        = s2_oe_q;
  assign bus.err       = s2_err_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.drive_cnt = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: reference model with per-cycle output checking plus literal expectations.
module tb_logic_unit_pipe;

  localparam int unsigned W = 8;

  typedef struct {
    logic [7:0] y;
    logic [7:0] oe;
    logic       err;
    logic       zero;
    logic       par;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_unit_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  int tot_acc = 0;
  bit lat_chk = 0;

  exp_t exp_q[$];
  int   cyc_q[$];
  exp_t got_q[$];
  logic [7:0] m_acc = 8'h00;

  bit   stall_prev = 0;
  exp_t snap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] ea, input logic [7:0] b);
    exp_t r;
    r.y = 8'h00; r.oe = 8'hFF; r.err = 1'b0;
    case (op)
      4'd0:  r.y = ea & b;
      4'd1:  r.y = ea | b;
      4'd2:  r.y = ~(ea & b);
      4'd3:  r.y = ~(ea | b);
      4'd4:  r.y = ea ^ b;
      4'd5:  r.y = ~(ea ^ b);
      4'd6:  r.y = ea;
      4'd7:  r.y = ~ea;
      4'd8:  begin r.y = ea;  r.oe = b;  end
      4'd9:  begin r.y = ea;  r.oe = ~b; end
      4'd10: begin r.y = ~ea; r.oe = b;  end
      4'd11: begin r.y = ~ea; r.oe = ~b; end
      default: begin r.y = 8'h00; r.oe = 8'h00; r.err = 1'b1; end
    endcase
    r.zero = ((r.y & r.oe) == 8'h00);
    r.par  = ($countones(r.y & r.oe) % 2) == 1;
    r.cnt  = 4'($countones(r.oe));
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Output checking against the model, then model update for this cycle's accept.
  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      m_acc = 8'h00;
      stall_prev = 0;
    end else begin
      if (bus.out_valid) begin
        if (stall_prev) begin
          chk("stall_y",    32'(bus.y),         32'(snap.y));
          chk("stall_oe",   32'(bus.oe),        32'(snap.oe));
          chk("stall_err",  32'(bus.err),       32'(snap.err));
          chk("stall_zero", 32'(bus.zero),      32'(snap.zero));
          chk("stall_par",  32'(bus.parity),    32'(snap.par));
          chk("stall_cnt",  32'(bus.drive_cnt), 32'(snap.cnt));
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_output: got y=%0h with nothing outstanding (t=%0t)", bus.y, $time);
          end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("out_y",    32'(bus.y),         32'(e.y));
            chk("out_oe",   32'(bus.oe),        32'(e.oe));
            chk("out_err",  32'(bus.err),       32'(e.err));
            chk("out_zero", 32'(bus.zero),      32'(e.zero));
            chk("out_par",  32'(bus.parity),    32'(e.par));
            chk("out_cnt",  32'(bus.drive_cnt), 32'(e.cnt));
            if (lat_chk) chk("latency", 32'(cyc - c), 32'd2);
          end
          e.y = bus.y; e.oe = bus.oe; e.err = bus.err;
          e.zero = bus.zero; e.par = bus.parity; e.cnt = bus.drive_cnt;
          got_q.push_back(e);
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          snap.y = bus.y; snap.oe = bus.oe; snap.err = bus.err;
          snap.zero = bus.zero; snap.par = bus.parity; snap.cnt = bus.drive_cnt;
        end
      end else begin
        stall_prev = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.op, bus.chain ? m_acc : bus.a, bus.b);
        if (!e.err) m_acc = e.y;
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        tot_acc++;
      end
    end
  end

  // Called with inputs aligned just after a rising edge; returns aligned the same way.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.op = op; bus.a = a; bus.b = b; bus.chain = ch;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] t1_y  [12] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00,
                             8'hC5, 8'h3A, 8'hC5, 8'hC5, 8'h3A, 8'h3A};
  logic [7:0] t1_oe [12] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                             8'hFF, 8'hFF, 8'h3A, 8'hC5, 8'h3A, 8'hC5};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.chain = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y",         32'(bus.y),         32'd0);
    chk("rst_oe",        32'(bus.oe),        32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_zero",      32'(bus.zero),      32'd1);
    chk("rst_parity",    32'(bus.parity),    32'd0);
    chk("rst_cnt",       32'(bus.drive_cnt), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;

    // All twelve legal opcodes back-to-back
    got_q.delete();
    lat_chk = 1;
    for (int i = 0; i < 12; i++) send(4'(i), 8'hC5, 8'h3A, 1'b0);
    drain();
    lat_chk = 0;
    chk("t1_count", 32'(got_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      chk($sformatf("t1_y_op%0d", i),  32'(got_q[i].y),  32'(t1_y[i]));
      chk($sformatf("t1_oe_op%0d", i), 32'(got_q[i].oe), 32'(t1_oe[i]));
    end

    // Flags
    got_q.delete();
    send(4'd8, 8'hF0, 8'h3C, 1'b0);
    send(4'd8, 8'h0F, 8'hF0, 1'b0);
    drain();
    if (got_q.size() >= 2) begin
      chk("fl_y",     32'(got_q[0].y),    32'hF0);
      chk("fl_oe",    32'(got_q[0].oe),   32'h3C);
      chk("fl_zero0", 32'(got_q[0].zero), 32'd0);
      chk("fl_par0",  32'(got_q[0].par),  32'd0);
      chk("fl_cnt0",  32'(got_q[0].cnt),  32'd4);
      chk("fl_zero1", 32'(got_q[1].zero), 32'd1);
      chk("fl_cnt1",  32'(got_q[1].cnt),  32'd4);
    end else chk("fl_count", 32'(got_q.size()), 32'd2);

    // Accumulator chain across an illegal op
    got_q.delete();
    send(4'd4,  8'h55, 8'h0F, 1'b0);
    send(4'd4,  8'h00, 8'hFF, 1'b1);
    send(4'd13, 8'h00, 8'h00, 1'b0);
    send(4'd0,  8'h00, 8'hF0, 1'b1);
    drain();
    if (got_q.size() >= 4) begin
      chk("ch_y0",   32'(got_q[0].y),   32'h5A);
      chk("ch_y1",   32'(got_q[1].y),   32'hA5);
      chk("ch_err2", 32'(got_q[2].err), 32'd1);
      chk("ch_y2",   32'(got_q[2].y),   32'h00);
      chk("ch_oe2",  32'(got_q[2].oe),  32'h00);
      chk("ch_err3", 32'(got_q[3].err), 32'd0);
      chk("ch_y3",   32'(got_q[3].y),   32'hA0);
    end else chk("ch_count", 32'(got_q.size()), 32'd4);

    // Backpressure
    got_q.delete();
    acc0 = tot_acc;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(4'd6, 8'(i + 1), 8'h00, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
        chk("bp_accepts",   32'(tot_acc - acc0), 32'd2);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("bp_y%0d", i), 32'(got_q[i].y), 32'(i + 1));

    // Reset with work in flight
    got_q.delete();
    send(4'd6, 8'h5A, 8'h00, 1'b0);
    drain();
    bus.out_ready = 1'b0;
    send(4'd6, 8'h5A, 8'h00, 1'b0);
    send(4'd6, 8'h5A, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_y",         32'(bus.y),         32'd0);
    chk("mr_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_no_flush_out", 32'(got_q.size()), 32'd1);
    @(posedge clk); #1;
    send(4'd6, 8'hFF, 8'h00, 1'b1);
    drain();
    if (got_q.size() >= 2) begin
      chk("mr_chain_y",    32'(got_q[1].y),    32'h00);
      chk("mr_chain_zero", 32'(got_q[1].zero), 32'd1);
    end else chk("mr_count", 32'(got_q.size()), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined successor to the two-input gate-primitive selector. It applies one of twelve bitwise gate/tristate operations across WIDTH-bit operands. Tristate behaviour is carried as an explicit output-enable vector instead of `z`, so the block is synthesizable. It adds a valid/ready handshake on both sides, an accumulator chain mode, and registered result flags, and it sits as a streaming bit-manipulation stage between producer and consumer datapaths.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CW, $clog2(WIDTH+1), width of the drive-count output (derived, not overridden)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts input this cycle
- a  in  WIDTH  operand A / data input of buffer and tristate ops
- b  in  WIDTH  operand B / per-bit control for tristate ops
- op  in  4  operation code
- chain  in  1  1 = replace `a` with the accumulator for this transaction
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result data
- oe  out  WIDTH  per-bit drive enable (1 = driven)
- err  out  1  op was illegal (12–15)
- zero  out  1  no driven bit is 1, i.e. ~|(y & oe)
- parity  out  1  ^(y & oe)
- drive_cnt  out  CW  popcount(oe)

## Operation
- Accept occurs when in_valid && in_ready. Effective A is `chain ? acc : a`.
- Opcodes, bitwise, with defaults y = result and oe = all ones:
  - 0 AND
  - 1 OR
  - 2 NAND
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 BUF (y=A)
  - 7 NOT (y=~A)
- Tristate opcodes:
  - 8 BUFIF1: y=A, oe=b
  - 9 BUFIF0: y=A, oe=~b
  - 10 NOTIF1: y=~A, oe=b
  - 11 NOTIF0: y=~A, oe=~b
- The tristate ops always use port `b` as control, even when chain=1.
- Opcodes 12–15 are illegal: y=0, oe=0, err=1, and acc is not updated. err=0 for legal ops.
- acc (WIDTH bits, internal) is loaded with y, ignoring oe, on every accepted legal transaction. A chained op therefore sees the y of the immediately preceding accepted legal op, with no hazard.
- Stage 1 registers y, oe and err on accept. Stage 2 registers y, oe and err, and computes zero, parity and drive_cnt from the stage-1 registers.
- Order is preserved, with no drops or duplicates.

## Timing
- Latency is 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 transaction/cycle when out_ready=1.
- Stage 2 loads when s1_v && (!s2_v || out_ready).
- in_ready = !s1_v || !s2_v || out_ready. This is combinational from out_ready; there is no combinational path from in_valid.
- While out_valid && !out_ready, all outputs hold stable and do not change until the handshake completes.
- Pipeline full (both stages valid) with out_ready=0 gives in_ready=0. A simultaneous out_ready=1 and in_valid=1 on a full pipe shifts both stages and accepts new input in the same cycle.
- Reset values:
  - s1_v=0, s2_v=0, acc=0
  - out_valid=0, y=0, oe=0, err=0
  - zero=1, parity=0, drive_cnt=0
  - in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation discards all in-flight transactions and clears acc. Nothing accepted before reset appears at the output.
- rst has priority over every handshake in the same cycle.
- chain=1 on the first transaction after reset uses acc=0.

## Structure
- Package logic_unit_pkg:
  - op_e enum with OP_AND=0 … OP_NOTIF0=11
  - OP_LAST=11 for the legality check
- Sub-module logic_unit_core: purely combinational. Inputs are A, b and op; outputs are y, oe and err. It is instantiated once in stage 1.
- Flag computation (reduction, popcount) is inline in stage 2.

## Test plan
- WIDTH=8, out_ready=1. Send ops 0–11 with a=0xC5, b=0x3A. Expect y/oe of, in order:
  - 00/FF, FF/FF, FF/FF, 00/FF, FF/FF, 00/FF
  - C5/FF, 3A/FF, C5/3A, C5/C5, 3A/3A, 3A/C5
  - Each result appears 2 cycles after accept, back-to-back.
- Flags: OP_BUFIF1, a=0xF0, b=0x3C. Expect y=F0, oe=3C, zero=0, parity=0, drive_cnt=4. Then a=0x0F, b=0xF0 gives zero=1, drive_cnt=4.
- Chain: XOR a=0x55,b=0x0F (y=5A), then XOR chain=1,b=0xFF (y=A5), then op 13 (err=1, y=0, oe=0), then AND chain=1,b=0xF0. Expect y=A0, since acc is unchanged by the illegal op.
- Backpressure: stream 5 transactions and hold out_ready=0 for 4 cycles.
  - Expect in_ready=0 after 2 accepts and outputs stable while stalled.
  - On release, all 5 results arrive in order with no loss.
- Reset mid-stream: 2 transactions in flight plus acc=0x5A, then assert rst for 1 cycle.
  - Expect out_valid=0 next cycle and neither in-flight result delivered.
  - A following chain=1 BUF yields y=0x00.
